spi_minion_frontend: RTL

//  SPI minion physical/framing stage directly upstream of the chip's SPI interconnect.

---
 rtl/spi_minion_pkg.sv | 27 ++
 rtl/spi_pad_sync.sv | 34 +++
 rtl/spi_minion_frontend.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/spi_minion_pkg.sv
// Shared types and constants for the SPI minion frontend.
package spi_minion_pkg;

  // Frame-handling phases of the minion.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Default frame geometry: {val, spc, payload}, MSB first.
  localparam int DEF_BIT_WIDTH = 34;
  localparam int VAL_BIT       = DEF_BIT_WIDTH - 1;
  localparam int SPC_BIT       = DEF_BIT_WIDTH - 2;

  // Pad positions inside the synchroniser bundle.
  localparam int NUM_PADS = 3;
  localparam int PAD_MOSI = 0;
  localparam int PAD_SCLK = 1;
  localparam int PAD_CS   = 2;

  // Bit counter width: must hold 0..BW+1 (saturation point).
  function automatic int cnt_w(input int bw);
    return $clog2(bw + 2);
  endfunction

endpackage

// File: rtl/spi_pad_sync.sv
// Multi-flop synchroniser for one asynchronous pad, with rise/fall detect
// taken from the last two synchronised samples.
module spi_pad_sync #(
  parameter int N_SYNC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pad,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [N_SYNC-1:0] r_sync;
  logic              r_prev;

  // Shift the pad through the chain and keep one older sample for edge detection.
  // The chain clears to 0, so a pad already low when reset releases produces no
  // falling edge; a high pad only yields a rise, which idle logic ignores.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[N_SYNC-2:0], i_pad};
      r_prev <= r_sync[N_SYNC-1];
    end
  end

  assign o_sync = r_sync[N_SYNC-1];
  assign o_rise = r_sync[N_SYNC-1] & ~r_prev;
  assign o_fall = ~r_sync[N_SYNC-1] & r_prev;

endmodule

// File: rtl/spi_minion_frontend.sv
// SPI minion framing stage: synchronises pads, deserialises one frame per
// cs-low window, hands the payload to a val/rdy stream and shifts the
// outbound payload onto miso.
module spi_minion_frontend
  import spi_minion_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int N_SYNC    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 sclk,
  input  logic                 mosi,
  output logic                 miso,
  output logic [BIT_WIDTH-3:0] recv_msg,
  output logic                 recv_val,
  input  logic                 recv_rdy,
  input  logic [BIT_WIDTH-3:0] send_msg,
  input  logic                 send_val,
  output logic                 send_rdy,
  output logic                 parity
);

  localparam int VAL_IDX    = BIT_WIDTH - 1;
  localparam int SPC_IDX    = BIT_WIDTH - 2;
  localparam int CNT_WIDTH  = cnt_w(BIT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(BIT_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(BIT_WIDTH);

  // ---------------------------------------------------------------- pads
  logic [NUM_PADS-1:0] w_pad_raw;
  logic [NUM_PADS-1:0] w_sync;
  logic [NUM_PADS-1:0] w_rise;
  logic [NUM_PADS-1:0] w_fall;
  logic                w_unused;

  assign w_pad_raw[PAD_MOSI] = mosi;
  assign w_pad_raw[PAD_SCLK] = sclk;
  assign w_pad_raw[PAD_CS]   = cs;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      spi_pad_sync #(.N_SYNC(N_SYNC)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_pad  (w_pad_raw[gi]),
        .o_sync (w_sync[gi]),
        .o_rise (w_rise[gi]),
        .o_fall (w_fall[gi])
      );
    end
  endgenerate

  // Sink for synchroniser outputs this block has no use for.
  assign w_unused = ^{w_sync[PAD_CS], w_sync[PAD_SCLK], w_rise[PAD_MOSI], w_fall[PAD_MOSI]};

  // ---------------------------------------------------------------- state
  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_enter;
  logic                   w_frame_ok;
  logic                   w_push;
  logic                   w_send_rdy;

  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [BIT_WIDTH-1:0]   r_shift_in;
  logic [BIT_WIDTH-1:0]   r_shift_out;
  logic                   r_tx_val;
  logic                   r_spc_sent;

  logic [BIT_WIDTH-3:0]   r_recv_msg;
  logic                   r_recv_val;
  logic                   r_parity;

  // FSM state register; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode plus the one-cycle commit decisions.
  always_comb begin
    w_state_next = r_state;
    w_enter      = 1'b0;
    w_frame_ok   = 1'b0;
    w_push       = 1'b0;
    w_send_rdy   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall[PAD_CS]) begin
          w_state_next = ACTIVE;
          w_enter      = 1'b1;
        end
      end
      ACTIVE: begin
        // Any sclk edge in this same cycle is still applied by the datapath.
        if (w_rise[PAD_CS]) w_state_next = COMMIT;
      end
      COMMIT: begin
        w_state_next = IDLE;
        w_frame_ok   = (r_cnt == CNT_FULL);
        w_push       = w_frame_ok & r_shift_in[VAL_IDX] & r_spc_sent;
        w_send_rdy   = w_frame_ok & r_tx_val & r_shift_in[SPC_IDX];
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Frame datapath: snapshot on cs fall, shift on synchronised sclk edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_tx_val    <= 1'b0;
      r_spc_sent  <= 1'b0;
    end else if (w_enter) begin
      // Advertise space only if the single-entry buffer is empty right now.
      r_cnt       <= '0;
      r_tx_val    <= send_val;
      r_spc_sent  <= ~r_recv_val;
      r_shift_out <= {send_val, ~r_recv_val, send_msg};
    end else if (r_state == ACTIVE) begin
      if (w_rise[PAD_SCLK]) begin
        r_shift_in <= {r_shift_in[BIT_WIDTH-2:0], w_sync[PAD_MOSI]};
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (w_fall[PAD_SCLK]) r_shift_out <= {r_shift_out[BIT_WIDTH-2:0], 1'b0};
    end
  end

  // Single-entry receive buffer; a new push wins over a same-cycle drain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_recv_val <= 1'b0;
      r_recv_msg <= '0;
      r_parity   <= 1'b0;
    end else if (w_push) begin
      r_recv_val <= 1'b1;
      r_recv_msg <= r_shift_in[BIT_WIDTH-3:0];
      r_parity   <= ^r_shift_in[BIT_WIDTH-3:0];
    end else if (r_recv_val && recv_rdy) begin
      r_recv_val <= 1'b0;
    end
  end

  assign miso     = (r_state == ACTIVE) & r_shift_out[BIT_WIDTH-1];
  assign recv_msg = r_recv_msg;
  assign recv_val = r_recv_val;
  assign send_rdy = w_send_rdy;
  assign parity   = r_parity;

endmodule
